// File: rtl/nibble_scan_ctrl.sv
// Nibble scan controller: steps a select index through a window and streams the
// selected nibbles over valid/ready. Optional running checksum: NIBBLE_SCAN_CHKSUM_EN.
module nibble_scan_ctrl #(
   parameter int SEL_W = 8,
   parameter int DAT_W = 4,
   parameter int LEN_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [SEL_W-1:0] base,
   input  logic [LEN_W-1:0] len,
   input  logic             dir,
   output logic [SEL_W-1:0] sel,
   input  logic [DAT_W-1:0] mux_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DAT_W-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             done
`ifdef NIBBLE_SCAN_CHKSUM_EN
   ,
   output logic [DAT_W-1:0] chk
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(1 << SEL_W);
   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

   logic [1:0]       state_r;
   logic [SEL_W-1:0] sel_r;
   logic [LEN_W-1:0] rem_r;
   logic             dir_r;
   logic             out_valid_r;
   logic [DAT_W-1:0] out_data_r;
   logic             out_last_r;
   logic             busy_r;
   logic             done_r;

   logic             cap_s;
   logic [SEL_W-1:0] next_sel_s;
   logic [LEN_W-1:0] len_clamp_s;

   // Capture enable, next index (wraps naturally at SEL_W bits) and clamped length.
   always_comb begin
      cap_s       = !out_valid_r || out_ready;
      next_sel_s  = sel_r;
      len_clamp_s = len;
      if (dir_r) begin
         next_sel_s = sel_r - SEL_ONE;
      end else begin
         next_sel_s = sel_r + SEL_ONE;
      end
      if (len > LEN_MAX) begin
         len_clamp_s = LEN_MAX;
      end else begin
         len_clamp_s = len;
      end
   end

   // Scan state machine and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         sel_r       <= {SEL_W{1'b0}};
         rem_r       <= LEN_ZERO;
         dir_r       <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {DAT_W{1'b0}};
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  if (len == LEN_ZERO) begin
                     done_r <= 1'b1;
                  end else begin
                     sel_r   <= base;
                     rem_r   <= len_clamp_s;
                     dir_r   <= dir;
                     busy_r  <= 1'b1;
                     state_r <= RUN;
                  end
               end
            end
            RUN: begin
               if (cap_s) begin
                  out_data_r  <= mux_y;
                  out_valid_r <= 1'b1;
                  out_last_r  <= (rem_r == REM_ONE);
                  rem_r       <= rem_r - REM_ONE;
                  // The final index stays on sel after the last capture.
                  if (rem_r == REM_ONE) begin
                     state_r <= DRAIN;
                  end else begin
                     sel_r <= next_sel_s;
                  end
               end
            end
            DRAIN: begin
               if (out_valid_r && out_ready) begin
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
                  done_r      <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

`ifdef NIBBLE_SCAN_CHKSUM_EN
   logic [DAT_W-1:0] chk_r;

   // Running XOR of captured nibbles; cleared on an accepted start, held after done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_r <= {DAT_W{1'b0}};
      end else if ((state_r == IDLE) && start) begin
         chk_r <= {DAT_W{1'b0}};
      end else if ((state_r == RUN) && cap_s) begin
         chk_r <= chk_r ^ mux_y;
      end else begin
         chk_r <= chk_r;
      end
   end

   assign chk = chk_r;
`endif

   assign sel       = sel_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_nibble_scan_ctrl.sv
// Self-checking bench for nibble_scan_ctrl: scoreboard of expected beats and
// capture indices, plus per-scenario timing and handshake checks.
module tb_nibble_scan_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [7:0]   base;
   logic [8:0]   len;
   logic         dir;
   logic [7:0]   sel;
   logic [3:0]   mux_y;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_data;
   logic         out_last;
   logic         busy;
   logic         done;
`ifdef NIBBLE_SCAN_CHKSUM_EN
   logic [3:0]   chk;
`endif

   logic [1023:0] word;
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int beat_cnt = 0;
   logic [4:0] exp_beat[$];
   logic [7:0] exp_sel[$];
   logic [4:0] mon_beat;
   logic [7:0] mon_sel;

   always #5 clk = ~clk;

   assign mux_y = word[{sel, 2'b00} +: 4];

   nibble_scan_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len), .dir(dir),
      .sel(sel), .mux_y(mux_y), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
`ifdef NIBBLE_SCAN_CHKSUM_EN
      , .chk(chk)
`endif
   );

   // Scoreboard: capture index at each capture, beat contents at each transfer.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (rst_n) begin
         if (busy && exp_sel.size() > 0 && (!out_valid || out_ready)) begin
            mon_sel = exp_sel.pop_front();
            checks++;
            if (sel !== mon_sel) begin
               errors++;
               $display("FAIL capture_sel got %0d exp %0d", sel, mon_sel);
            end
         end
         if (out_valid && out_ready) begin
            beat_cnt++;
            checks++;
            if (exp_beat.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat got data %h last %b exp none", out_data, out_last);
            end else begin
               mon_beat = exp_beat.pop_front();
               if ({out_last, out_data} !== mon_beat) begin
                  errors++;
                  $display("FAIL beat got last %b data %h exp last %b data %h",
                           out_last, out_data, mon_beat[4], mon_beat[3:0]);
               end
            end
         end
      end
   end

   task automatic start_scan(input logic [7:0] b, input logic [8:0] l, input logic d, input bit push);
      logic [7:0] idx;
      start = 1'b1; base = b; len = l; dir = d;
      if (push) begin
         for (int i = 0; i < int'(l); i++) begin
            idx = d ? 8'(int'(b) - i) : 8'(int'(b) + i);
            exp_sel.push_back(idx);
            exp_beat.push_back({(i == int'(l) - 1), word[{idx, 2'b00} +: 4]});
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int last_c, output int done_c);
      last_c = -1;
      done_c = -1;
      for (int c = 0; c < limit; c++) begin
         if (out_valid && out_last && last_c < 0) last_c = c;
         if (done) begin
            done_c = c;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; base = 8'd0; len = 9'd0; dir = 1'b0; out_ready = 1'b1;
      word = 1024'h1234ABCD;
      #2;
      checks++;
      if ({sel, out_data, out_valid, out_last, busy, done} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state got sel %0d data %h v %b l %b busy %b done %b exp all zero",
                  sel, out_data, out_valid, out_last, busy, done);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_forward();
      int last_c, done_c, b0;
      b0 = beat_cnt;
      out_ready = 1'b1;
      start_scan(8'd0, 9'd8, 1'b0, 1'b1);
      checks++;
      if (sel !== 8'd0 || out_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL fwd_start got sel %0d v %b busy %b exp 0 0 1", sel, out_valid, busy);
      end
      wait_done(40, last_c, done_c);
      checks++;
      if (last_c !== 8 || done_c !== 9) begin
         errors++;
         $display("FAIL fwd_timing got last %0d done %0d exp 8 9", last_c, done_c);
      end
      checks++;
      if (beat_cnt - b0 !== 8 || exp_beat.size() !== 0) begin
         errors++;
         $display("FAIL fwd_beats got %0d left %0d exp 8 0", beat_cnt - b0, exp_beat.size());
      end
`ifdef NIBBLE_SCAN_CHKSUM_EN
      checks++;
      if (chk !== 4'h4) begin
         errors++;
         $display("FAIL fwd_chk got %h exp 4", chk);
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fwd_idle got done %b busy %b v %b exp 0 0 0", done, busy, out_valid);
      end
   endtask

   task automatic test_reverse();
      int last_c, done_c;
      start_scan(8'd7, 9'd8, 1'b1, 1'b1);
      wait_done(40, last_c, done_c);
      checks++;
      if (done_c !== 9 || exp_beat.size() !== 0 || exp_sel.size() !== 0 || sel !== 8'd0) begin
         errors++;
         $display("FAIL rev_end got done %0d left %0d sel %0d exp 9 0 0", done_c, exp_beat.size(), sel);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      int last_c, done_c;
      start_scan(8'd254, 9'd4, 1'b0, 1'b1);
      wait_done(40, last_c, done_c);
      checks++;
      if (done_c !== 5 || last_c !== 4 || exp_beat.size() !== 0 || sel !== 8'd1) begin
         errors++;
         $display("FAIL wrap_end got done %0d last %0d left %0d sel %0d exp 5 4 0 1",
                  done_c, last_c, exp_beat.size(), sel);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int last_c, done_c, b0;
      b0 = beat_cnt;
      out_ready = 1'b0;
      start_scan(8'd0, 9'd8, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 4'hD || sel !== 8'd1) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got v %b data %h sel %0d exp 1 d 1", k, out_valid, out_data, sel);
         end
      end
      out_ready = 1'b1;
      wait_done(40, last_c, done_c);
      checks++;
      if (done_c < 0 || beat_cnt - b0 !== 8 || exp_beat.size() !== 0) begin
         errors++;
         $display("FAIL bp_stream got done %0d beats %0d left %0d exp >=0 8 0",
                  done_c, beat_cnt - b0, exp_beat.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_len0_busy();
      int last_c, done_c, d0, b0;
      d0 = done_cnt;
      start_scan(8'd5, 9'd0, 1'b0, 1'b0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL len0_pulse got done %b busy %b v %b exp 1 0 0", done, busy, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0 || done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL len0_after got done %b v %b pulses %0d exp 0 0 1", done, out_valid, done_cnt - d0);
      end
      b0 = beat_cnt;
      d0 = done_cnt;
      start_scan(8'd0, 9'd8, 1'b0, 1'b1);
      @(posedge clk); #1;
      start_scan(8'h10, 9'd4, 1'b1, 1'b0);
      wait_done(40, last_c, done_c);
      repeat (3) begin
         @(posedge clk); #1;
      end
      checks++;
      if (beat_cnt - b0 !== 8 || done_cnt - d0 !== 1 || busy !== 1'b0 || exp_beat.size() !== 0) begin
         errors++;
         $display("FAIL busy_start got beats %0d dones %0d busy %b exp 8 1 0",
                  beat_cnt - b0, done_cnt - d0, busy);
      end
   endtask

   task automatic test_reset_mid();
      int last_c, done_c, d0, b0;
      out_ready = 1'b1;
      b0 = beat_cnt;
      d0 = done_cnt;
      start_scan(8'd0, 9'd8, 1'b0, 1'b1);
      repeat (4) begin
         @(posedge clk); #1;
      end
      checks++;
      if (beat_cnt - b0 !== 3) begin
         errors++;
         $display("FAIL mid_beats got %0d exp 3", beat_cnt - b0);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || sel !== 8'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got v %b busy %b sel %0d done %b exp 0 0 0 0", out_valid, busy, sel, done);
      end
      exp_beat.delete();
      exp_sel.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      checks++;
      if (done_cnt !== d0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_nodone got pulses %0d v %b exp 0 0", done_cnt - d0, out_valid);
      end
      start_scan(8'd7, 9'd8, 1'b1, 1'b1);
      wait_done(40, last_c, done_c);
      checks++;
      if (done_c !== 9 || exp_beat.size() !== 0) begin
         errors++;
         $display("FAIL mid_rescan got done %0d left %0d exp 9 0", done_c, exp_beat.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_wrap();
      test_backpressure();
      test_len0_busy();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_scan_ctrl.md
Name: nibble_scan_ctrl

Overview:
- Sequential scan controller that drives the select input of the 256-way 4-bit selector and consumes its 4-bit output.
- Steps a select index through a programmed window (base, length, direction), with wrap-around.
- Captures each selected nibble into an output register and streams it downstream over a valid/ready handshake with back-pressure.
- Sits between the control/bus logic and the nibble selector, turning a wide parallel word into a nibble stream.

Parameters:
- SEL_W, 8, select width; the index space is 2**SEL_W entries.
- DAT_W, 4, nibble width.
- LEN_W, 9, length field width; must hold the value 2**SEL_W.

Ports:
- clk  in  1  Single clock, rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- start  in  1  One-cycle request; sampled only in IDLE.
- base  in  SEL_W  First index of the scan; sampled with start.
- len  in  LEN_W  Number of nibbles to scan; sampled with start.
- dir  in  1  0 = increment index, 1 = decrement; sampled with start.
- sel  out  SEL_W  Registered select index, driven to the selector.
- mux_y  in  DAT_W  Selector output; combinational function of sel.
- out_valid  out  1  Output register holds a nibble.
- out_ready  in  1  Downstream accepts the nibble.
- out_data  out  DAT_W  Captured nibble.
- out_last  out  1  Qualifies the final nibble of the scan.
- busy  out  1  High in any state other than IDLE.
- done  out  1  One-cycle pulse when the scan completes.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; sel, out_data, remaining count = 0; out_valid, out_last, busy, done = 0.
- Length handling: len is clamped to 2**SEL_W.
  - len=0 with start: no beats are produced; done pulses on the next cycle; state stays IDLE.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 and len!=0 -> sel<=base, rem<=len, latch dir, go to RUN.
- RUN, capture condition: cap = !out_valid || out_ready.
  - If cap: out_data<=mux_y, out_valid<=1, out_last<=(rem==1), rem<=rem-1.
  - Also if cap: sel<=sel+1 (dir=0) or sel-1 (dir=1), modulo 2**SEL_W (255->0 incrementing, 0->255 decrementing).
  - If cap and rem==1: go to DRAIN and hold sel.
  - If !cap: hold sel, rem and the output register; mux_y is ignored.
- DRAIN: when out_valid && out_ready -> out_valid<=0, out_last<=0, done<=1 for one cycle, go to IDLE.
- Handshake:
  - A beat transfers on any cycle with out_valid && out_ready.
  - out_data and out_last stay stable while out_valid=1 && out_ready=0.
  - out_valid never drops without a transfer, except on reset.
- Latency and throughput:
  - start accepted at edge N -> sel=base after edge N -> first out_valid after edge N+1.
  - With out_ready held high: 1 nibble per cycle; len nibbles take len+1 cycles from start to the last beat.
- Simultaneous events:
  - start while busy is ignored.
  - A beat transfer and a new capture in the same cycle is a legal back-to-back transfer.
- sel is registered only; there is no combinational path from start to sel.
- Reset mid-scan aborts immediately: no done pulse; the in-flight beat is discarded.

Optional Feature:
- Macro: NIBBLE_SCAN_CHKSUM_EN.
- Defined:
  - Adds output port chk (DAT_W bits).
  - Running XOR of every captured nibble; cleared on reset and when start is accepted.
  - Holds its final value from the done pulse until the next accepted start.
- Undefined: no chk port and no checksum logic.

Test Plan:
1. Word 1024'h1234ABCD on the selector, base=0, len=8, dir=0, out_ready=1.
   - out_data = D,C,B,A,4,3,2,1 on consecutive cycles.
   - out_last only on the beat carrying 1; done one cycle after it.
   - With the macro defined: chk=4.
2. Same word, base=7, len=8, dir=1.
   - out_data = 1,2,3,4,A,B,C,D; sel visits 7 down to 0.
3. Wrap-around: base=254, len=4, dir=0.
   - sel sequence 254,255,0,1; out_data = 0,0,D,C.
4. Back-pressure: scenario 1 with out_ready=0 for 3 cycles after the first valid.
   - out_data holds D and sel holds 1 during the stall.
   - Stream resumes with no lost or duplicated nibbles.
5. len=0 -> done pulses once and out_valid stays 0.
   - start issued while busy -> ignored; scan and beat count unchanged.
6. rst_n low mid-scan after 3 beats.
   - Immediately: out_valid=0, busy=0, sel=0, no done pulse.
   - A new start then scans correctly.
